// File: rtl/regfft_pkg.sv
// Shared definitions for the regfft frame sequencer: state encoding, frame geometry
// and the address bit-reverse helper used for FFT input reordering.
package regfft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_UNLOAD  = 2'd3
  } regfft_state_t;

  localparam int REGFFT_DATA_W    = 38;
  localparam int REGFFT_ADDR_W    = 6;
  localparam int REGFFT_FRAME_LEN = 32'd1 << REGFFT_ADDR_W;

  // Reverses the low w bits of v (w <= 16); bits above w come back as zero.
  function automatic logic [15:0] bit_reverse(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = {<<{v}};
    return r >> (32'd16 - w);
  endfunction

endpackage

// File: rtl/regfftr.sv
// Single-port register file for one regfft frame; synchronous read, contents are
// not cleared by reset. A write cycle does not update the read register.
module regfftr #(
  parameter int DATA_W = 38,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              regfft_wren,
  input  logic [ADDR_W-1:0] regfft_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Single port: either write the addressed word or capture it for reading.
  always_ff @(posedge clk) begin
    if (regfft_wren) begin
      r_mem[regfft_addr] <= data_in;
    end else begin
      data_out <= r_mem[regfft_addr];
    end
  end

endmodule

// File: rtl/regfft_seq.sv
// Frame sequencer: loads 2**ADDR_W samples into regfftr in natural order, then unloads
// them. Optional macro REGFFT_BITREV_EN selects bit-reversed unload order.
import regfft_pkg::*;

module regfft_seq #(
  parameter int DATA_W = REGFFT_DATA_W,
  parameter int ADDR_W = REGFFT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  regfft_state_t     r_state;
  regfft_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_wren;
  logic              w_done_nxt;
  logic [ADDR_W-1:0] w_unload_addr;
  logic [ADDR_W-1:0] w_rf_addr;
  logic [DATA_W-1:0] w_rf_rdata;
  logic              r_busy;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_done;

`ifdef REGFFT_BITREV_EN
  logic [15:0] w_rev;
  assign w_rev         = bit_reverse({{(16-ADDR_W){1'b0}}, r_cnt}, ADDR_W);
  assign w_unload_addr = w_rev[ADDR_W-1:0];
`else
  assign w_unload_addr = r_cnt;
`endif

  // Loads always address in natural order; every other state reads the unload address.
  assign w_rf_addr = (r_state == ST_LOAD) ? r_cnt : w_unload_addr;

  regfftr #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfftr (
    .clk         (clk),
    .regfft_wren (w_wren),
    .regfft_addr (w_rf_addr),
    .data_in     (in_data),
    .data_out    (w_rf_rdata)
  );

  // Next-state, counter and write-enable decode; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wren      = 1'b0;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (in_valid && r_in_ready) begin
            w_wren = 1'b1;
            if (r_cnt == CNT_MAX) begin
              w_state_nxt = ST_RD_WAIT;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else begin
            w_wren = 1'b0;
          end
        end
        ST_RD_WAIT: begin
          w_state_nxt = ST_UNLOAD;
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (r_cnt == CNT_MAX) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RD_WAIT;
              w_cnt_nxt   = r_cnt + CNT_ONE;
            end
          end else begin
            w_state_nxt = ST_UNLOAD;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_in_ready  <= (w_state_nxt == ST_LOAD);
      r_out_valid <= (w_state_nxt == ST_UNLOAD);
      r_out_last  <= (w_state_nxt == ST_UNLOAD) && (w_cnt_nxt == CNT_MAX);
      r_done      <= w_done_nxt;
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;
  // Read data is only meaningful while presenting a sample; hold zero otherwise.
  assign out_data  = w_rf_rdata & {DATA_W{r_out_valid}};

endmodule

// File: tb/tb_regfft_seq.sv
// Self-checking bench for regfft_seq: random load/unload traffic against an array model
// of the frame, plus abort, mid-frame reset and ignored-input scenarios.
module tb_regfft_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [37:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int          passed;
  int          total;
  logic [37:0] ref_mem [64];

  regfft_seq #(
    .DATA_W (38),
    .ADDR_W (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample k of the unload stream comes from this frame position.
  function automatic int exp_addr(input int k);
    int r;
    r = k;
`ifdef REGFFT_BITREV_EN
    begin
      int v;
      r = 0;
      v = k;
      for (int i = 0; i < 6; i++) begin
        r = r * 2 + v % 2;
        v = v / 2;
      end
    end
`endif
    return r;
  endfunction

  task automatic load_frame(input int gap_pct, input bit idx_data, input int stop_at);
    int n;
    int cyc;
    int rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_entry", 64'({busy, in_ready, out_valid, done}), 64'(4'b1100));
    n   = 0;
    cyc = 0;
    rdy = 0;
    while (n < stop_at && cyc < 4000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = idx_data ? 38'(n) : 38'({$urandom, $urandom});
      start    = ($urandom_range(15) == 0);
      if (in_ready) rdy++;
      if (in_valid && in_ready) begin
        ref_mem[n] = in_data;
        n++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("load_count", 64'(n), 64'(stop_at));
    chk("load_ready_cycles", 64'(rdy), 64'(cyc));
    if (gap_pct == 0) chk("load_cycles", 64'(cyc), 64'(stop_at));
    if (stop_at == 64) chk("rd_wait_entry", 64'({busy, in_ready, out_valid, done}), 64'(4'b1000));
  endtask

  task automatic unload_frame(input int stall_pct, input int stop_at);
    int k;
    int cyc;
    int dones;
    k     = 0;
    cyc   = 0;
    dones = 0;
    while (k < stop_at && cyc < 4000) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (done) dones++;
      if (out_valid) begin
        chk("unload_data", 64'(out_data), 64'(ref_mem[exp_addr(k)]));
        chk("unload_last", 64'(out_last), 64'(k == 63));
        if (out_ready) k++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("unload_count", 64'(k), 64'(stop_at));
    chk("unload_no_early_done", 64'(dones), 64'(0));
    if (stop_at == 64) begin
      chk("done_pulse", 64'({done, busy, out_valid, in_ready}), 64'(4'b1000));
      if (stall_pct == 0) chk("unload_cycles", 64'(cyc), 64'(128));
      tick();
      chk("done_clear", 64'({done, busy}), 64'(2'b00));
    end
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 38'd0;
    out_ready = 1'b0;
    #3;
    chk("reset_outputs", 64'({busy, in_ready, out_valid, out_last, done}), 64'(5'b00000));
    #10;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 64'({busy, in_ready, out_valid, done}), 64'(4'b0000));

    // in_valid in IDLE must not start anything
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 38'({$urandom, $urandom});
      tick();
      chk("idle_in_valid", 64'({busy, in_ready, out_valid}), 64'(3'b000));
    end
    in_valid = 1'b0;

    // index frame, full-rate unload
    load_frame(0, 1'b1, 64);
    unload_frame(0, 64);

    // random data with input gaps and output stalls
    load_frame(30, 1'b0, 64);
    unload_frame(40, 64);

    // abort together with start after 20 loads
    load_frame(0, 1'b1, 20);
    abort    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    tick();
    abort    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("abort_idle", 64'({busy, in_ready, out_valid, done}), 64'(4'b0000));
    tick();
    chk("abort_no_done", 64'({busy, done}), 64'(2'b00));
    load_frame(25, 1'b0, 64);
    unload_frame(0, 64);

    // reset in the middle of unloading sample 10
    load_frame(0, 1'b0, 64);
    unload_frame(30, 10);
    tick();
    chk("mid_unload_valid", 64'({busy, out_valid}), 64'(2'b11));
    rst = 1'b1;
    #1;
    chk("mid_reset_status", 64'({busy, in_ready, out_valid, out_last, done}), 64'(5'b00000));
    chk("mid_reset_data", 64'(out_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    load_frame(10, 1'b0, 64);
    unload_frame(50, 64);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfft_seq.md
REGFFT_SEQ -- requirements
Module: regfft_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 38, sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; frame length is 2**ADDR_W (64) samples.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-006 SHALL have port abort  input  1  synchronous frame cancel.
REQ-007 SHALL have port in_valid / in_ready  input / output  1 / 1  load-stream handshake.
REQ-008 SHALL have port in_data  input  DATA_W  load sample.
REQ-009 SHALL have port out_valid / out_ready  output / input  1 / 1  unload-stream handshake.
REQ-010 SHALL have port out_data  output  DATA_W  unload sample.
REQ-011 SHALL have port out_last  output  1  marks the final unload sample of the frame.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last unload handshake.

Function
REQ-014 SHALL implement states IDLE, LOAD, RD_WAIT and UNLOAD.
REQ-015 IDLE: start=1 SHALL move to LOAD with address counter = 0; in_ready=0 and out_valid=0 in IDLE.
REQ-016 LOAD: in_ready SHALL be 1; each in_valid&in_ready cycle SHALL write in_data to the register file at counter (natural order) and increment counter.
REQ-017 On the write at counter = 2**ADDR_W-1, the counter SHALL wrap to 0 and the state SHALL go to RD_WAIT.
REQ-018 RD_WAIT: the register file SHALL be read at the unload address; the state SHALL go to UNLOAD next cycle with out_valid=1.
REQ-019 UNLOAD: out_data SHALL equal the register-file read data; out_valid, out_data and out_last SHALL stay stable until out_ready=1.
REQ-020 An out handshake SHALL increment the counter and return to RD_WAIT, so maximum unload throughput is one sample per two cycles.
REQ-021 The handshake with out_last=1 (counter = 2**ADDR_W-1) SHALL go to IDLE, pulse done for one cycle, and leave the counter at 0.
REQ-022 Write enable and read SHALL never coincide; the write enable SHALL be high only on LOAD handshakes.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 abort=1 in any state SHALL go to IDLE next cycle with counter = 0 and no done pulse; abort SHALL take priority over start and over any same-cycle handshake.
REQ-025 The load sample stall length SHALL be unbounded; gaps in in_valid SHALL not affect addressing.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, counter = 0, in_ready = 0, out_valid = 0, out_last = 0, done = 0 and busy = 0.
REQ-027 Reset SHALL NOT clear register-file contents; reset mid-frame discards the frame.

Configuration
REQ-028 With REGFFT_BITREV_EN defined, the unload address SHALL be the ADDR_W-bit bit-reverse of the counter, which is FFT input reordering.
REQ-029 Without REGFFT_BITREV_EN, the unload address SHALL equal the counter, which is natural order; all other behaviour is identical.

Structure
REQ-030 SHALL instantiate exactly one sub-module: the existing 64x38 single-port register file regfftr, connecting regfft_wren, regfft_addr, data_in and data_out.
REQ-031 The state encoding and the frame-length constant SHALL live in shared package regfft_pkg; the bit-reverse function SHALL also be placed there.

Verification
REQ-032 Reset, start, then 64 loads of in_data = index with in_valid held high -> in_ready high for exactly 64 cycles, then the state reaches RD_WAIT.
REQ-033 With BITREV on, unload with out_ready=1 -> out_data sequence 0, 32, 16, 48, 8, ...; out_last on the 64th sample; done pulses once; 128 cycles from the first RD_WAIT to IDLE.
REQ-034 With BITREV off and random out_ready -> out_data = 0..63 in order, held stable during stalls, with no duplicates or drops.
REQ-035 abort asserted after 20 loads, in the same cycle as start -> IDLE next cycle, no done pulse; a new frame then loads from address 0.
REQ-036 rst pulsed mid-UNLOAD at sample 10 -> all outputs are 0 immediately, IDLE, and start is accepted afterwards.
REQ-037 start pulsed during LOAD, and in_valid pulsed during IDLE -> no state change and no write.
